// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a common-anode, N-digit
// seven-segment display.
//
// A value arrives through a valid/ready handshake into a one-entry pending
// buffer. It moves into the display register only while idle or at a frame
// boundary, so a frame never mixes old and new digits. Each digit slot has a
// blanking interval followed by a drive interval.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           scan enable (0 forces idle)
//   value_i      hex value, nibble k drives digit k (digit 0 least significant)
//   value_valid  value_i valid
//   value_ready  pending buffer empty (registered)
//   frame_done   one-cycle pulse on the last drive cycle of the last digit
//   digit_an     active-low one-hot digit enable
//   hex_o        nibble for the current digit, to the 7-segment decoder
//   blank_o      1 = segments off
//
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN
//   When defined, digits above 0 whose nibble and all higher nibbles are zero
//   stay dark for their whole drive interval.
module ssd_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic                  frame_done,
  output logic [N_DIGITS-1:0]   digit_an,
  output logic [3:0]            hex_o,
  output logic                  blank_o
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned IW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SlotLast  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;

  logic                  accept;
  logic                  transfer;
  logic [3:0]            nib;
  logic                  dark;

  logic [N_DIGITS-1:0]   an_d;
  logic [3:0]            hex_d;
  logic                  blank_d;
  logic                  fd_d;

  assign accept   = value_valid && value_ready;
  // frame_done is high during the boundary cycle, so the load lands on the
  // same edge that starts digit 0 of the next frame.
  assign transfer = pend_full_q && ((state_q == StIdle) || frame_done);

  // Scan sequencing. The slot counter runs 0..SLOT_CYCLES-1 across blank and
  // drive; the blank/drive split is decided by comparing against BlankLast.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BlankLast) state_d = StDrive;
        end
        StDrive: begin
          if (cnt_q == SlotLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pending buffer and display register.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    if (transfer) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end
    // Never coincides with transfer: ready is low while pending is full.
    if (accept) begin
      pend_d      = value_i;
      pend_full_d = 1'b1;
    end
  end

  // Nibble of the digit being entered, taken from the next display value so a
  // boundary load is shown from the first cycle of the new frame.
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IW'(k)) nib = disp_d[4*k +: 4];
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lead_zero;

  // lead_zero[k]: nibble k and every nibble above it are zero.
  always_comb begin
    lead_zero             = '0;
    lead_zero[N_DIGITS-1] = (disp_d[4*(N_DIGITS-1) +: 4] == 4'h0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] && (disp_d[4*k +: 4] == 4'h0);
    end
    dark = 1'b0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (idx_d == IW'(k)) dark = lead_zero[k];
    end
  end
`else
  assign dark = 1'b0;
`endif

  // Output values for the state being entered; registered below.
  always_comb begin
    an_d    = '1;
    hex_d   = 4'h0;
    blank_d = 1'b1;
    fd_d    = 1'b0;
    unique case (state_d)
      StIdle: ;
      StBlank: hex_d = nib;
      StDrive: begin
        hex_d = nib;
        fd_d  = (idx_d == IdxLast) && (cnt_d == SlotLast);
        if (!dark) begin
          blank_d = 1'b0;
          for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IW'(k)) an_d[k] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      value_ready <= 1'b1;
      frame_done  <= 1'b0;
      digit_an    <= '1;
      hex_o       <= 4'h0;
      blank_o     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      value_ready <= ~pend_full_d;
      frame_done  <= fd_d;
      digit_an    <= an_d;
      hex_o       <= hex_d;
      blank_o     <= blank_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl with default parameters (4 digits, 1000-cycle
// slots, 16 blank cycles). Position p counts edges after scanning starts:
// p = 0 is the first BLANK cycle of digit 0.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value_i;
  logic        value_valid;
  logic        value_ready;
  logic        frame_done;
  logic [3:0]  digit_an;
  logic [3:0]  hex_o;
  logic        blank_o;

  int n_vec;
  int n_bad;
  int pos;

  ssd_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value_i     (value_i),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .frame_done  (frame_done),
    .digit_an    (digit_an),
    .hex_o       (hex_o),
    .blank_o     (blank_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          p;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        blank;
    logic        fd;
    logic        rdy;
    logic        load;
    logic [15:0] val;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic adv_to(input int p);
    while (pos < p) tick();
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at p=%0d: got %h, expected %h", name, pos, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [3:0] hex,
                         input logic blank, input logic fd, input logic rdy);
    chk({tag, ".digit_an"}, 16'(digit_an), 16'(an));
    chk({tag, ".hex_o"}, 16'(hex_o), 16'(hex));
    chk({tag, ".blank_o"}, 16'(blank_o), 16'(blank));
    chk({tag, ".frame_done"}, 16'(frame_done), 16'(fd));
    chk({tag, ".value_ready"}, 16'(value_ready), 16'(rdy));
  endtask

  task automatic load_idle(input logic [15:0] v);
    en          = 1'b0;
    tick();
    value_i     = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    pos         = 0;
    rst         = 1'b0;
    en          = 1'b0;
    value_i     = 16'h0;
    value_valid = 1'b0;

    //            p     an       hex   bl    fd    rdy   load  val
    vecs[0]  = '{0,    4'b1111, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[1]  = '{15,   4'b1111, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[2]  = '{16,   4'b1110, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[3]  = '{999,  4'b1110, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[4]  = '{1000, 4'b1111, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[5]  = '{1016, 4'b1101, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[6]  = '{1100, 4'b1101, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 16'hABCD};
    vecs[7]  = '{1101, 4'b1101, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[8]  = '{2016, 4'b1011, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[9]  = '{3016, 4'b0111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[10] = '{3998, 4'b0111, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[11] = '{3999, 4'b0111, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[12] = '{4000, 4'b1111, 4'hD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[13] = '{4016, 4'b1110, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[14] = '{5016, 4'b1101, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[15] = '{6016, 4'b1011, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[16] = '{7016, 4'b0111, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0};
    vecs[17] = '{7999, 4'b0111, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};
    vecs[18] = '{8000, 4'b1111, 4'hD, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};

    // Reset asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_out("reset_no_clk", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk_out("idle", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);

    // Load while idle: ready low for exactly one cycle.
    value_i     = 16'h1234;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("idle_load.ready_low", 16'(value_ready), 16'h0);
    tick();
    chk("idle_load.ready_back", 16'(value_ready), 16'h1);

    // Scan two frames, with a tear-free update loaded during digit 1.
    en  = 1'b1;
    pos = -1;
    for (int i = 0; i < 19; i++) begin
      adv_to(vecs[i].p);
      chk_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].hex, vecs[i].blank, vecs[i].fd,
              vecs[i].rdy);
      if (vecs[i].load) begin
        value_i     = vecs[i].val;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
      end
    end

    // Drop en mid-drive on digit 2, then re-enable.
    adv_to(10500);
    chk_out("pre_drop", 4'b1011, 4'hB, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    chk_out("en_drop", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    chk_out("en_drop_hold", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    en  = 1'b1;
    pos = -1;
    adv_to(0);
    chk_out("reen_blank", 4'b1111, 4'hD, 1'b1, 1'b0, 1'b1);
    adv_to(16);
    chk_out("reen_drive", 4'b1110, 4'hD, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-drive while a value is pending.
    adv_to(100);
    value_i     = 16'h5678;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("pend_held.ready", 16'(value_ready), 16'h0);
    #3 rst = 1'b1;
    #1;
    chk_out("async_reset", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b0;
    pos = -1;
    adv_to(0);
    chk_out("post_rst_blank", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    adv_to(16);
    chk_out("post_rst_drive", 4'b1110, 4'h0, 1'b0, 1'b0, 1'b1);
    adv_to(4000);
    chk_out("pend_lost", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);

`ifdef SSD_LEADING_ZERO_BLANK_EN
    load_idle(16'h00A0);
    en  = 1'b1;
    pos = -1;
    adv_to(16);
    chk_out("lz_a0.d0", 4'b1110, 4'h0, 1'b0, 1'b0, 1'b1);
    adv_to(1016);
    chk_out("lz_a0.d1", 4'b1101, 4'hA, 1'b0, 1'b0, 1'b1);
    adv_to(2016);
    chk_out("lz_a0.d2", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    adv_to(3016);
    chk_out("lz_a0.d3", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);

    load_idle(16'h0000);
    en  = 1'b1;
    pos = -1;
    adv_to(16);
    chk_out("lz_00.d0", 4'b1110, 4'h0, 1'b0, 1'b0, 1'b1);
    adv_to(1016);
    chk_out("lz_00.d1", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
    adv_to(3016);
    chk_out("lz_00.d3", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b1);
`else
    // Without leading-zero blanking, a zero upper digit is still driven.
    load_idle(16'h00A0);
    en  = 1'b1;
    pos = -1;
    adv_to(3016);
    chk_out("nolz_a0.d3", 4'b0111, 4'h0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
